shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
- Sequential unsigned multiplier controller.
- Time-shares one external WIDTH-bit combinational adder (the team's carry-select adder) to build a 2*WIDTH-bit product by shift-and-add, one iteration per clock.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Owns the state machine, iteration counter and partial-product registers. The adder is reached only through the add_* ports.

Parameters:
WIDTH, 32, operand width; adder width; number of iterations.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  controller can accept operands
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
out_valid  output  1  product available
out_ready  input  1  sink accepts product
out_product  output  2*WIDTH  unsigned product in_a*in_b
busy  output  1  high in RUN or DONE
add_a  output  WIDTH  adder operand A
add_b  output  WIDTH  adder operand B
add_cin  output  1  adder carry-in, constant 0
add_sum  input  WIDTH  adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  adder carry-out

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports clk and rst.
- Registers:
  - state: IDLE, RUN or DONE.
  - mcand: WIDTH bits.
  - hi: WIDTH bits.
  - lo: WIDTH bits.
  - cnt: CNT_W bits.
- Reset, at a clk edge with rst=1:
  - state=IDLE; mcand, hi, lo and cnt = 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, out_product=0.
  - rst has priority over every other event, including mid-RUN and DONE. Any in-flight operation is discarded and no result is produced.
- Output decode (combinational from state):
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
  - out_product = {hi,lo}, driven in all states.
- Adder drive:
  - In RUN: add_a=hi, add_b = lo[0] ? mcand : 0, add_cin=0.
  - In IDLE/DONE: add_a=0, add_b=0, add_cin=0.
- IDLE:
  - When in_valid && in_ready at an edge: mcand<=in_a, hi<=0, lo<=in_b, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN, every edge:
  - {hi,lo} <= {add_cout, add_sum, lo[WIDTH-1:1]}, i.e. the (WIDTH+1)-bit sum concatenated with lo, shifted right by one.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, state<=DONE.
  - Exactly WIDTH iterations; no early termination, even for zero operands.
- DONE:
  - out_product is stable and held for as long as out_valid=1 && out_ready=0.
  - At an edge with out_ready=1: state<=IDLE. The hi/lo registers keep their last value.
- Latency and throughput:
  - Acceptance edge k → out_valid first observed after edge k+WIDTH.
  - Earliest next acceptance is at edge k+WIDTH+2 (with out_ready tied high).
- Ignored inputs:
  - in_valid while busy is ignored; operands are not captured and not queued.
  - in_a/in_b changes after acceptance have no effect.
  - out_ready outside DONE is ignored.
- Arithmetic:
  - Unsigned.
  - add_cout is never lost; it becomes hi[WIDTH-1] after the shift.
  - The full product range 0 .. (2^WIDTH-1)^2 is exact.
- Simultaneous events:
  - rst with a handshake: reset wins.
  - in_valid asserted in the same cycle DONE is left: not accepted, because in_ready is still 0 that cycle. It is accepted on the following cycle if still valid.

Test Plan:
- Basic product: reset; in_a=3, in_b=5, in_valid pulse; out_ready=1 → out_valid rises 32 edges after acceptance with out_product=64'h0000_0000_0000_000F; busy high during RUN/DONE; in_ready=1 two cycles after acceptance+32.
- Maximum operands: in_a=in_b=32'hFFFF_FFFF → out_product=64'hFFFF_FFFE_0000_0001. Confirms carry-out capture.
- Zero and identity:
  - in_a=0, in_b=32'hDEAD_BEEF → 0, still 32-cycle latency.
  - in_a=32'h1234_5678, in_b=1 → 64'h0000_0000_1234_5678.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_valid and out_product (7*9=63) stay constant; in_valid with new operands during the stall is ignored. Releasing out_ready → IDLE next cycle, then new operands are accepted.
- Reset mid-operation: rst=1 at iteration 15 of 32'h8000_0000*2 → next cycle state IDLE, out_valid=0, out_product=0, in_ready=1. A subsequent 6*7 yields 42 with normal latency.
- Back-to-back: 100 random operand pairs streamed with in_valid held high and random out_ready → every product matches the reference model, results in order, none dropped or duplicated.

Source files
------------

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier controller.
// The operand source and result sink use the master side; the controller uses the slave side.
interface shift_add_mult_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_product;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product
   );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: one shift-and-add iteration per clock through a shared
// external WIDTH-bit adder, producing a 2*WIDTH-bit product after WIDTH iterations.
module shift_add_mult_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_add_mult_ctrl_if.slave bus,
   output logic                 busy,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic                 add_cin,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             last_iter;

   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.in_valid) state_d = StRun;
         StRun:   if (last_iter) state_d = StDone;
         StDone:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.in_ready    = (state_q == StIdle);
      bus.out_valid   = (state_q == StDone);
      busy            = (state_q != StIdle);
      bus.out_product = {hi_q, lo_q};
      add_cin         = 1'b0;
      add_a           = '0;
      add_b           = '0;
      if (state_q == StRun) begin
         add_a = hi_q;
         add_b = lo_q[0] ? mcand_q : '0;
      end
   end

   // The adder carry-out lands in hi's MSB, so no product bit is ever dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  mcand_q <= bus.in_a;
                  hi_q    <= '0;
                  lo_q    <= bus.in_b;
                  cnt_q   <= '0;
               end
            end
            StRun: begin
               {hi_q, lo_q} <= {add_cout, add_sum, lo_q[WIDTH-1:1]};
               cnt_q        <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed cases plus a randomized stream
// checked against plain a*b products held in an in-order queue.
module tb_shift_add_mult_ctrl;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             busy;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_cout;

   int checks   = 0;
   int failures = 0;

   shift_add_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

   shift_add_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Stand-in for the external carry-select adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Assumes out_ready=1 and the controller idle at a negedge on entry.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      int          lat;
      logic [63:0] exp;
      exp = {32'b0, a} * {32'b0, b};
      chk({tag, "_in_ready_pre"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      chk({tag, "_busy_run"}, 64'(busy), 64'd1);
      chk({tag, "_add_cin"}, 64'(add_cin), 64'd0);
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd32);
      chk({tag, "_product"}, bus.out_product, exp);
      chk({tag, "_busy_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({tag, "_in_ready_post"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      int          lat;
      int          accepted;
      int          compared;
      int          cycles;
      logic [63:0] ref_q[$];
      logic [63:0] exp;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_product", bus.out_product, 64'd0);
      chk("idle_add_b", 64'(add_b), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("basic", 32'd3, 32'd5);
      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("max_const", bus.out_product, 64'hFFFF_FFFE_0000_0001);
      run_op("zero", 32'd0, 32'hDEAD_BEEF);
      run_op("ident", 32'h1234_5678, 32'd1);

      // Backpressure: product must hold while the sink stalls; new operands are ignored.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'd7;
      bus.in_b      = 32'd9;
      @(negedge clk);
      bus.in_a = 32'd11;
      bus.in_b = 32'd13;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'd32);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_product", bus.out_product, 64'd63);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
      chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_held_product", bus.out_product, 64'd63);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_next_accepted", 64'(busy), 64'd1);
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_next_latency", 64'(lat), 64'd32);
      chk("bp_next_product", bus.out_product, 64'd143);
      @(negedge clk);

      // Reset in the middle of an operation
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h8000_0000;
      bus.in_b     = 32'd2;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_product", bus.out_product, 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      run_op("after_rst", 32'd6, 32'd7);
      chk("after_rst_const", bus.out_product, 64'd42);

      // Randomized stream: in_valid held high with fresh operands every cycle.
      accepted = 0;
      compared = 0;
      cycles   = 0;
      while (compared < 100 && cycles < 8000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.in_valid  = (accepted < 100);
         bus.in_a      = $urandom;
         bus.in_b      = $urandom;
         if (bus.in_valid && bus.in_ready) begin
            ref_q.push_back({32'b0, bus.in_a} * {32'b0, bus.in_b});
            accepted++;
         end
         if (bus.out_valid && bus.out_ready) begin
            exp = (ref_q.size() > 0) ? ref_q.pop_front() : 64'hX;
            chk("stream_product", bus.out_product, exp);
            compared++;
         end
         @(negedge clk);
         cycles++;
      end
      bus.in_valid = 1'b0;
      chk("stream_count", 64'(compared), 64'd100);
      chk("stream_leftover", 64'(ref_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
